// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch-stage prefetch queue.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 5;
    localparam int FETCH_DATA_W = 32;

    // One queued fetch result: the address and the instruction word fetched from it.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Occupancy needs one more bit than the pointers so that "full" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = $bits(fetch_entry_t),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [PTR_W-1:0]   i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]   i_rd_addr,
    output logic [ENTRY_W-1:0] o_rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    // Capture the incoming entry at the write pointer.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch FIFO between instruction memory and decode. in_ready doubles as
// the program counter's count enable, so it depends on registered occupancy only.
// Optional build macro: INSTR_FETCH_QUEUE_BYPASS_EN lets a fetch into an empty
// queue reach decode in the same cycle.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int DATA_W  = FETCH_DATA_W,
    localparam int CNT_W  = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ENT_W-1:0] w_wr_data;
    logic [ENT_W-1:0] w_rd_data;
    logic             w_not_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_store;
    logic             w_unload;

    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != FULL_CNT);
    assign count       = r_count;

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch side straight to decode unless redirecting.
    assign w_bypass = ~w_not_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = w_not_empty | w_bypass;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    // A bypassed entry that decode takes immediately never touches storage.
    assign w_store   = w_push & ~(w_bypass & out_ready);
    assign w_unload  = w_pop & w_not_empty;
    assign w_wr_data = {in_pc, in_instr};

    fetch_queue_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENT_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_store & ~flush),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Head presentation: forwarded input, stored head, or zeros when nothing is valid.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (w_bypass) begin
            {out_pc, out_instr} = w_wr_data;
        end else if (w_not_empty) begin
            {out_pc, out_instr} = w_rd_data;
        end
    end

    // Pointer and occupancy bookkeeping; a redirect overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_unload) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_store, w_unload})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: the driver predicts which fetches are
// accepted and queues them; a separate monitor compares every presented head.
module tb_instr_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [ADDR_W-1:0] in_pc     = '0;
    logic [DATA_W-1:0] in_instr  = '0;
    logic              out_ready = 1'b0;
    logic              flush     = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [CNT_W-1:0]  count;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    instr_fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at posedge+1, predict acceptance at negedge, commit at posedge.
    task automatic drive_cycle(input bit v, input logic [ADDR_W-1:0] pc,
                               input logic [DATA_W-1:0] instr, input bit ordy, input bit fl);
        int   sz;
        bit   acc;
        ent_t e;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        sz = exp_q.size();
        check("count", count, sz);
        check("in_ready", in_ready, sz != DEPTH);
        acc = v && (sz != DEPTH) && !fl;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
        if (sz == 0 && v && ordy) acc = 1'b0;
`endif
        e.pc    = pc;
        e.instr = instr;
        $display("cyc v=%0b pc=%0d ordy=%0b flush=%0b occ=%0d accept=%0b", v, pc, ordy, fl, sz, acc);
        @(posedge clk);
        if (acc) exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares the presented head against the scoreboard and retires pops.
    initial begin
        bit   byp;
        ent_t h;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                byp = 1'b0;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
                byp = (exp_q.size() == 0) && in_valid && !flush;
`endif
                if (byp) begin
                    check("bypass_valid", out_valid, 1'b1);
                    check("bypass_pc", out_pc, in_pc);
                    check("bypass_instr", out_instr, in_instr);
                end else if (exp_q.size() == 0) begin
                    check("empty_valid", out_valid, 1'b0);
                    check("empty_pc", out_pc, '0);
                    check("empty_instr", out_instr, '0);
                end else begin
                    h = exp_q[0];
                    check("head_valid", out_valid, 1'b1);
                    check("head_pc", out_pc, h.pc);
                    check("head_instr", out_instr, h.instr);
                    if (out_ready && !flush) begin
                        void'(exp_q.pop_front());
                        $display("pop pc=%0d instr=%08h", h.pc, h.instr);
                    end
                end
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] pc_ctr;
        // Reset state while rst_n is held low.
        #3;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, one extra fetch held off, then drain in order.
        for (int p = 0; p < 4; p++) drive_cycle(1'b1, ADDR_W'(p), 32'hA000_0000 + p, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd4, 32'hA000_0004, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);

        // Streaming at occupancy 2 across pointer wrap.
        drive_cycle(1'b1, 5'd0, 32'hB000_0000, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd1, 32'hB000_0001, 1'b0, 1'b0);
        for (int p = 2; p < 12; p++) drive_cycle(1'b1, ADDR_W'(p), 32'hB000_0000 + p, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with a simultaneous push and pop.
        for (int p = 4; p < 7; p++) drive_cycle(1'b1, ADDR_W'(p), 32'hC000_0000 + p, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd7, 32'hC000_0007, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'd8, 32'hC000_0008, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);

        // Asynchronous reset between edges with two entries queued.
        drive_cycle(1'b1, 5'd20, 32'hD000_0014, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd21, 32'hD000_0015, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #2;
        check("arst_count", count, 0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_pc", out_pc, 0);
        check("arst_out_instr", out_instr, 0);
        exp_q.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 5'd22, 32'hD000_0016, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Fetch into an empty queue with decode ready.
        drive_cycle(1'b1, 5'd9, 32'hA000_0009, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);

        // Randomised traffic with occasional redirects.
        pc_ctr = 5'd0;
        for (int i = 0; i < 400; i++) begin
            bit v, r, f;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 99) < 5);
            drive_cycle(v, pc_ctr, $urandom, r, f);
            if (v) pc_ctr = pc_ctr + 5'd1;
        end
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
